program_sequencer: RTL

PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

---
 rtl/micro_pkg.sv | 27 ++
 rtl/program_sequencer_if.sv | 27 ++
 rtl/ps_stack.sv | 52 +++++
 rtl/program_sequencer.sv | 125 ++++++++++++
 4 files changed

// File: rtl/micro_pkg.sv
// Shared widths, constants and the fetch-source encoding for the program
// sequencer and its return-address stack.
package micro_pkg;

  localparam int PM_ADDR_W       = 8;
  localparam int JMP_ADDR_W      = 4;
  localparam int STACK_DEPTH_DEF = 4;

  // Stack pointer is wide enough for 0..8 entries.
  localparam int SP_W = 4;

  // Bit positions inside the from_PS debug word.
  localparam int FPS_OVF_BIT = 7;
  localparam int FPS_UNF_BIT = 6;
  localparam int FPS_SP_MSB  = 2;

  // Where the next fetch address comes from, in falling priority.
  typedef enum logic [2:0] {
    SEL_RESET,
    SEL_HOLD,
    SEL_RET,
    SEL_CALL,
    SEL_JUMP,
    SEL_INC
  } fetch_sel_e;

endpackage

// File: rtl/program_sequencer_if.sv
// Control/fetch bus between the instruction decoder (master) and the
// program sequencer (slave).
interface program_sequencer_if;
  import micro_pkg::*;

  logic                  hold;
  logic                  jmp;
  logic                  jmp_nz;
  logic                  dont_jmp;
  logic                  call;
  logic                  ret;
  logic [JMP_ADDR_W-1:0] jmp_addr;
  logic [PM_ADDR_W-1:0]  pm_addr;
  logic [PM_ADDR_W-1:0]  pc;
  logic [PM_ADDR_W-1:0]  from_PS;

  modport master (
    output hold, jmp, jmp_nz, dont_jmp, call, ret, jmp_addr,
    input  pm_addr, pc, from_PS
  );

  modport slave (
    input  hold, jmp, jmp_nz, dont_jmp, call, ret, jmp_addr,
    output pm_addr, pc, from_PS
  );

endinterface

// File: rtl/ps_stack.sv
// Return-address LIFO for the program sequencer. Push and pop are assumed
// mutually exclusive; a push when full or a pop when empty is ignored.
// Contents are not reset, only the pointer.
module ps_stack
  import micro_pkg::*;
#(
  parameter int DEPTH = STACK_DEPTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic                 pop,
  input  logic [PM_ADDR_W-1:0] push_data,
  output logic [PM_ADDR_W-1:0] top,
  output logic                 full,
  output logic                 empty,
  output logic [SP_W-1:0]      sp
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PM_ADDR_W-1:0] mem_q [DEPTH];
  logic [SP_W-1:0]      sp_q;
  logic [IDX_W-1:0]     wr_idx;
  logic [IDX_W-1:0]     rd_idx;

  assign wr_idx = IDX_W'(sp_q);
  assign rd_idx = IDX_W'(sp_q - 1'b1);
  assign full   = (sp_q == SP_W'(DEPTH));
  assign empty  = (sp_q == '0);
  assign top    = empty ? '0 : mem_q[rd_idx];
  assign sp     = sp_q;

  // Entry storage: written on an accepted push, never cleared.
  always_ff @(posedge clk) begin
    if (reset && push && !full) begin
      mem_q[wr_idx] <= push_data;
    end
  end

  // Stack pointer: grows on push, shrinks on pop, cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sp_q <= '0;
    end else if (push && !full) begin
      sp_q <= sp_q + 1'b1;
    end else if (pop && !empty) begin
      sp_q <= sp_q - 1'b1;
    end
  end

endmodule

// File: rtl/program_sequencer.sv
// Program sequencer: produces the next program-memory fetch address and
// holds the current pc. Optional call/return stack is enabled by defining
// PS_CALL_STACK_EN; without it call/ret are ignored and from_PS reads zero.
module program_sequencer
  import micro_pkg::*;
#(
  parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
  input  logic                clk,
  input  logic                reset,
  program_sequencer_if.slave  bus
);

  logic [PM_ADDR_W-1:0] pc_q;
  logic [PM_ADDR_W-1:0] pc_d;
  logic [PM_ADDR_W-1:0] pc_inc;
  logic [PM_ADDR_W-1:0] target;
  fetch_sel_e           sel;

  assign pc_inc = pc_q + PM_ADDR_W'(1);
  assign target = {bus.jmp_addr, {(PM_ADDR_W-JMP_ADDR_W){1'b0}}};

`ifdef PS_CALL_STACK_EN
  logic                 stk_push;
  logic                 stk_pop;
  logic                 stk_full;
  logic                 stk_empty;
  logic [PM_ADDR_W-1:0] stk_top;
  logic [SP_W-1:0]      stk_sp;
  logic                 ovf_q, ovf_d;
  logic                 unf_q, unf_d;

  ps_stack #(.DEPTH(STACK_DEPTH)) u_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (pc_inc),
    .top       (stk_top),
    .full      (stk_full),
    .empty     (stk_empty),
    .sp        (stk_sp)
  );

  // Pick the fetch source; ret beats call when both are asserted.
  always_comb begin
    sel = SEL_INC;
    if (!reset)                                sel = SEL_RESET;
    else if (bus.hold)                         sel = SEL_HOLD;
    else if (bus.ret)                          sel = SEL_RET;
    else if (bus.call)                         sel = SEL_CALL;
    else if (bus.jmp || (bus.jmp_nz && !bus.dont_jmp)) sel = SEL_JUMP;
  end

  // Stack requests and sticky error flags; a full push or empty pop only flags.
  always_comb begin
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (sel == SEL_RET) begin
      if (stk_empty) unf_d = 1'b1;
      else           stk_pop = 1'b1;
    end
    if (sel == SEL_CALL) begin
      if (stk_full) ovf_d = 1'b1;
      else          stk_push = 1'b1;
    end
  end

  // Sticky overflow/underflow registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Debug word: flags on top, low stack-pointer bits at the bottom.
  always_comb begin
    bus.from_PS                 = '0;
    bus.from_PS[FPS_OVF_BIT]    = ovf_q;
    bus.from_PS[FPS_UNF_BIT]    = unf_q;
    bus.from_PS[FPS_SP_MSB:0]   = stk_sp[FPS_SP_MSB:0];
  end
`else
  // Pick the fetch source; call and ret do not exist in this build.
  always_comb begin
    sel = SEL_INC;
    if (!reset)                                sel = SEL_RESET;
    else if (bus.hold)                         sel = SEL_HOLD;
    else if (bus.jmp || (bus.jmp_nz && !bus.dont_jmp)) sel = SEL_JUMP;
  end

  assign bus.from_PS = '0;
`endif

  // Next-fetch address mux, driven straight to program memory.
  always_comb begin
    pc_d = pc_inc;
    case (sel)
      SEL_RESET: pc_d = '0;
      SEL_HOLD:  pc_d = pc_q;
`ifdef PS_CALL_STACK_EN
      SEL_RET:   pc_d = stk_empty ? pc_inc : stk_top;
      SEL_CALL:  pc_d = target;
`endif
      SEL_JUMP:  pc_d = target;
      default:   pc_d = pc_inc;
    endcase
  end

  // Program counter follows the fetch address every edge.
  always_ff @(posedge clk) begin
    if (!reset) pc_q <= '0;
    else        pc_q <= pc_d;
  end

  assign bus.pm_addr = pc_d;
  assign bus.pc      = pc_q;

endmodule
